// File: rtl/aes_pkg.sv
// Shared AES definitions: word/round-key types, S-box, round constants and
// the key-schedule controller state encoding.
package aes_pkg;

  typedef logic [31:0]  aes_word_t;
  typedef logic [127:0] aes_rk_t;

  localparam int AES256_NUM_RK = 15;

  localparam logic [7:0] RCON [7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

  typedef enum logic [1:0] {
    KS_IDLE   = 2'd0,
    KS_EXPAND = 2'd1,
    KS_DONE   = 2'd2
  } ks_state_t;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    int unsigned pos;
    pos = (32'd255 - 32'(b)) * 32'd8;
    return SBOX_TBL[pos +: 8];
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel, purely combinational S-box lookups.
module aes_sub_word
  import aes_pkg::*;
(
  input  aes_word_t din,
  output aes_word_t dout
);

  // Byte-wise substitution
  always_comb begin
    dout = {sbox(din[31:24]), sbox(din[23:16]), sbox(din[15:8]), sbox(din[7:0])};
  end

endmodule

// File: rtl/aes256_key_sched_ctrl.sv
// Iterative AES-256 key schedule: one 128-bit round key per cycle into a
// 15-entry register file with a one-cycle read port. Optional zeroize port
// is enabled by defining AES_KS_ZEROIZE_EN.
module aes256_key_sched_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_RK = AES256_NUM_RK,
  parameter int IDX_W  = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
`ifdef AES_KS_ZEROIZE_EN
  input  logic             zeroize_i,
`endif
  input  logic [255:0]     key_i,
  input  logic             key_valid_i,
  output logic             key_ready_o,
  output logic             busy_o,
  output logic             keys_valid_o,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic             rd_valid_o,
  output logic [127:0]     rd_data_o
);

  ks_state_t state_r, state_n;
  logic [3:0] r_r, r_n;
  aes_rk_t    rk_r [NUM_RK];
  logic       key_ready_r, busy_r, keys_valid_r;
  logic       rd_valid_r;
  aes_rk_t    rd_data_r;

  logic       zero_s, load_s, step_s;
  aes_rk_t    a_s;
  aes_word_t  p3_s, sub_in_s, sub_out_s, t_s, w0_s, w1_s, w2_s, w3_s;
  logic [2:0] rcon_idx_s;

`ifdef AES_KS_ZEROIZE_EN
  assign zero_s = zeroize_i;
`else
  assign zero_s = 1'b0;
`endif

  aes_sub_word u_sub_word (
    .din  (sub_in_s),
    .dout (sub_out_s)
  );

  // Round-key step: even steps rotate and add rcon, odd steps substitute only
  always_comb begin
    a_s        = rk_r[r_r - 4'd2];
    p3_s       = rk_r[r_r - 4'd1][31:0];
    rcon_idx_s = r_r[3:1] - 3'd1;
    sub_in_s   = r_r[0] ? p3_s : {p3_s[23:0], p3_s[31:24]};
    t_s        = r_r[0] ? sub_out_s : (sub_out_s ^ {RCON[rcon_idx_s], 24'h000000});
    w0_s       = a_s[127:96] ^ t_s;
    w1_s       = a_s[95:64]  ^ w0_s;
    w2_s       = a_s[63:32]  ^ w1_s;
    w3_s       = a_s[31:0]   ^ w2_s;
  end

  // Next-state logic; zeroize overrides both key accept and expansion
  always_comb begin
    state_n = state_r;
    r_n     = r_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    if (zero_s) begin
      state_n = KS_IDLE;
      r_n     = 4'd0;
    end else begin
      case (state_r)
        KS_IDLE, KS_DONE: begin
          if (key_valid_i) begin
            load_s  = 1'b1;
            r_n     = 4'd2;
            state_n = KS_EXPAND;
          end else begin
            state_n = state_r;
          end
        end
        KS_EXPAND: begin
          step_s = 1'b1;
          if (r_r == 4'd14) begin
            state_n = KS_DONE;
          end else begin
            r_n = r_r + 4'd1;
          end
        end
        default: begin
          state_n = KS_IDLE;
          r_n     = 4'd0;
        end
      endcase
    end
  end

  // State, step counter and registered status outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r      <= KS_IDLE;
      r_r          <= 4'd0;
      key_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      keys_valid_r <= 1'b0;
    end else begin
      state_r      <= state_n;
      r_r          <= r_n;
      key_ready_r  <= (state_n != KS_EXPAND);
      busy_r       <= (state_n == KS_EXPAND);
      keys_valid_r <= (state_n == KS_DONE);
    end
  end

  // Round-key register file
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_RK; i++) rk_r[i] <= 128'h0;
    end else if (zero_s) begin
      for (int i = 0; i < NUM_RK; i++) rk_r[i] <= 128'h0;
    end else if (load_s) begin
      rk_r[0] <= key_i[255:128];
      rk_r[1] <= key_i[127:0];
    end else if (step_s) begin
      rk_r[r_r] <= {w0_s, w1_s, w2_s, w3_s};
    end
  end

  // Read port: sees pre-write contents, out-of-range index reads as zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_valid_r <= 1'b0;
      rd_data_r  <= 128'h0;
    end else begin
      rd_valid_r <= rd_en_i;
      if (zero_s) begin
        rd_data_r <= 128'h0;
      end else if (rd_en_i) begin
        rd_data_r <= (rd_idx_i < IDX_W'(NUM_RK)) ? rk_r[rd_idx_i] : 128'h0;
      end
    end
  end

  assign key_ready_o  = key_ready_r;
  assign busy_o       = busy_r;
  assign keys_valid_o = keys_valid_r;
  assign rd_valid_o   = rd_valid_r;
  assign rd_data_o    = rd_data_r;

endmodule

// File: tb/tb_aes256_key_sched_ctrl.sv
// Directed bench for aes256_key_sched_ctrl: table-driven round-key reads
// plus hand-written sequences for handshake, reset and zeroize corners.
module tb_aes256_key_sched_ctrl;
  import aes_pkg::*;

  localparam logic [255:0] KEY_A = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [255:0] KEY_B = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [255:0] key = 256'h0;
  logic         key_valid = 1'b0;
  logic         key_ready, busy, keys_valid;
  logic         rd_en = 1'b0;
  logic [3:0]   rd_idx = 4'd0;
  logic         rd_valid;
  logic [127:0] rd_data;
`ifdef AES_KS_ZEROIZE_EN
  logic         zeroize = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  logic [127:0] model_rk [15];

  typedef struct {
    logic [255:0] key;
    logic [3:0]   idx;
    logic [127:0] exp;
  } vec_t;
  vec_t vt [7];

  always #5 clk = ~clk;

  aes256_key_sched_ctrl dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
`ifdef AES_KS_ZEROIZE_EN
    .zeroize_i    (zeroize),
`endif
    .key_i        (key),
    .key_valid_i  (key_valid),
    .key_ready_o  (key_ready),
    .busy_o       (busy),
    .keys_valid_o (keys_valid),
    .rd_en_i      (rd_en),
    .rd_idx_i     (rd_idx),
    .rd_valid_o   (rd_valid),
    .rd_data_o    (rd_data)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Textbook word-wise key expansion over w[0..59]
  task automatic model_expand(input logic [255:0] k);
    logic [31:0] w [60];
    logic [31:0] t;
    for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      t = w[i-1];
      if (i % 8 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
        t = t ^ {RCON[i/8 - 1], 24'h000000};
      end else if (i % 8 == 4) begin
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
      end
      w[i] = w[i-8] ^ t;
    end
    for (int j = 0; j < 15; j++) model_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!keys_valid && lat < 40) begin
      tick;
      lat++;
    end
  endtask

  task automatic load_key(input logic [255:0] k, output int lat);
    key = k;
    key_valid = 1'b1;
    tick;
    key_valid = 1'b0;
    wait_done(lat);
  endtask

  task automatic rd(input logic [3:0] idx);
    rd_en = 1'b1;
    rd_idx = idx;
    tick;
    rd_en = 1'b0;
  endtask

  initial begin
    int lat;
    logic [255:0] cur;

    vt[0] = '{KEY_A, 4'd2,  128'h9ba354118e6925afa51a8b5f2067fcde};
    vt[1] = '{KEY_A, 4'd14, 128'hfe4890d1e6188d0b046df344706c631e};
    vt[2] = '{KEY_A, 4'd0,  128'h603deb1015ca71be2b73aef0857d7781};
    vt[3] = '{KEY_A, 4'd15, 128'h0};
    vt[4] = '{KEY_B, 4'd14, 128'h24fc79ccbf0979e9371ac23c6d68de36};
    vt[5] = '{KEY_B, 4'd1,  128'h101112131415161718191a1b1c1d1e1f};
    vt[6] = '{KEY_B, 4'd3,  128'h1651a8cd0244beda1a5da4c10640bade};

    // Reset state
    #12;
    chk("rst_key_ready", 128'(key_ready), 128'd1);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_keys_valid", 128'(keys_valid), 128'd0);
    chk("rst_rd_valid", 128'(rd_valid), 128'd0);
    chk("rst_rd_data", rd_data, 128'h0);
    rst_n = 1'b1;
    tick;
    rd(4'd5);
    chk("rst_rf_zero", rd_data, 128'h0);

    // Table-driven reads, reloading the key when the vector's key changes
    cur = 256'h0;
    for (int i = 0; i < 7; i++) begin
      if (vt[i].key !== cur) begin
        cur = vt[i].key;
        load_key(cur, lat);
        chk("latency", 128'(lat), 128'd13);
        chk("busy_done", 128'(busy), 128'd0);
      end
      rd(vt[i].idx);
      chk("vec_valid", 128'(rd_valid), 128'd1);
      chk($sformatf("vec%0d_rk%0d", i, vt[i].idx), rd_data, vt[i].exp);
    end

    // Back-to-back reads 14..0 on KEY_B
    model_expand(KEY_B);
    for (int i = 14; i >= 0; i--) begin
      rd_en = 1'b1;
      rd_idx = 4'(i);
      tick;
      chk("b2b_valid", 128'(rd_valid), 128'd1);
      chk($sformatf("b2b_rk%0d", i), rd_data, model_rk[i]);
    end
    rd_en = 1'b0;
    tick;
    chk("b2b_valid_drop", 128'(rd_valid), 128'd0);

    // Second key held during EXPAND is ignored until DONE
    key = KEY_A;
    key_valid = 1'b1;
    tick;
    key = KEY_B;
    tick;
    chk("hold_ready_low", 128'(key_ready), 128'd0);
    wait_done(lat);
    chk("hold_latency", 128'(lat), 128'd12);
    rd_en = 1'b1;
    rd_idx = 4'd14;
    tick;
    rd_en = 1'b0;
    key_valid = 1'b0;
    chk("hold_first_rk14", rd_data, 128'hfe4890d1e6188d0b046df344706c631e);
    chk("hold_accept_busy", 128'(busy), 128'd1);
    chk("hold_accept_kv", 128'(keys_valid), 128'd0);
    wait_done(lat);
    rd(4'd14);
    chk("hold_second_rk14", rd_data, 128'h24fc79ccbf0979e9371ac23c6d68de36);

    // Reset pulse at step r=7 with a read in flight
    key = KEY_A;
    key_valid = 1'b1;
    tick;
    key_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick;
    rd(4'd0);
    chk("pre_rst_read", rd_data, 128'h603deb1015ca71be2b73aef0857d7781);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_key_ready", 128'(key_ready), 128'd1);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_keys_valid", 128'(keys_valid), 128'd0);
    chk("mid_rst_rd_valid", 128'(rd_valid), 128'd0);
    chk("mid_rst_rd_data", rd_data, 128'h0);
    #3;
    rst_n = 1'b1;
    tick;
    rd(4'd1);
    chk("mid_rst_rf_zero", rd_data, 128'h0);
    model_expand(KEY_B);
    load_key(KEY_B, lat);
    chk("post_rst_latency", 128'(lat), 128'd13);
    rd(4'd7);
    chk("post_rst_rk7", rd_data, model_rk[7]);

`ifdef AES_KS_ZEROIZE_EN
    // Zeroize in DONE wipes the register file
    zeroize = 1'b1;
    tick;
    zeroize = 1'b0;
    chk("zero_kv", 128'(keys_valid), 128'd0);
    chk("zero_rd_data", rd_data, 128'h0);
    for (int i = 0; i < 15; i++) begin
      rd(4'(i));
      chk($sformatf("zero_rk%0d", i), rd_data, 128'h0);
    end
    // Zeroize coinciding with key accept
    key = KEY_A;
    key_valid = 1'b1;
    zeroize = 1'b1;
    tick;
    key_valid = 1'b0;
    zeroize = 1'b0;
    chk("zero_acc_busy", 128'(busy), 128'd0);
    chk("zero_acc_ready", 128'(key_ready), 128'd1);
    chk("zero_acc_kv", 128'(keys_valid), 128'd0);
    rd(4'd0);
    chk("zero_acc_rk0", rd_data, 128'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes256_key_sched_ctrl.md
# aes256_key_sched_ctrl

Sequential AES-256 key-schedule controller. It accepts a 256-bit master key over a valid/ready handshake and expands it iteratively, producing one 128-bit round key per cycle through a single shared SubWord unit. All 15 round keys are held in an internal register file. The cipher round engine reads them by index with one-cycle latency, in any order, for both encryption and decryption.

## Interface
- `NUM_RK`, 15: number of round keys stored. Fixed for AES-256; no other value is supported.
- `IDX_W`, 4: width of the round-key index.
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_ni` in 1: reset, asynchronous and active-low.
- `key_i` in 256: master key; `key_i[255:224]` is w0.
- `key_valid_i` in 1: master key offered.
- `key_ready_o` out 1: controller can accept a key. High in IDLE and DONE.
- `busy_o` out 1: expansion in progress.
- `keys_valid_o` out 1: all 15 round keys are valid for the currently loaded key.
- `rd_en_i` in 1: round-key read request.
- `rd_idx_i` in IDX_W: round-key index, 0..14.
- `rd_valid_o` out 1: read data valid. Asserted one cycle after `rd_en_i`.
- `rd_data_o` out 128: round key `{w[4i], w[4i+1], w[4i+2], w[4i+3]}`.
- `zeroize_i` in 1: present only with `AES_KS_ZEROIZE_EN`.

## Operation
- States: IDLE, EXPAND, DONE.
- Key accept: `key_valid_i && key_ready_o` at an edge.
  - rk[0] ← `key_i[255:128]`, rk[1] ← `key_i[127:0]`.
  - Step counter r ← 2; state → EXPAND.
- EXPAND, one step per cycle, computing rk[r] from rk[r-2] (a0..a3) and the last word p3 of rk[r-1]:
  - Even r: t = SubWord(RotWord(p3)) ^ {rcon[r/2-1], 24'h0}. rcon = 01,02,04,08,10,20,40.
  - Odd r: t = SubWord(p3).
  - w0 = a0^t, w1 = a1^w0, w2 = a2^w1, w3 = a3^w2. rk[r] ← {w0,w1,w2,w3}.
  - When r == 14, write rk[14] and go to DONE; otherwise r ← r+1.
- DONE: `keys_valid_o` = 1. A new key accept returns to the key-accept behaviour above and `keys_valid_o` clears on that edge.
- `key_ready_o` = 0 in EXPAND. `key_valid_i` is ignored there and the offered key must be held by the source.
- Reads are serviced in every state and return current register-file contents. Contents may be stale or partially generated when `keys_valid_o` = 0.
- `rd_idx_i` > 14: `rd_data_o` = 0, `rd_valid_o` still asserted.
- Widths: all arithmetic is 32-bit XOR; r is a 4-bit counter and never wraps past 14.

## Timing
- Reset values: `key_ready_o`=1, `busy_o`=0, `keys_valid_o`=0, `rd_valid_o`=0, `rd_data_o`=0. State = IDLE, r = 0, register file all-zero.
- Expansion latency: accept edge E0 writes rk0/rk1. Edges E1..E13 write rk2..rk14. `keys_valid_o` is high after E13, i.e. 13 cycles after accept. `busy_o` is high from after E0 until after E13.
- Read latency: exactly one cycle, fully pipelined, one read per cycle.
- Read and write of the same index in the same cycle: the read returns the pre-write value.
- Reset asserted mid-expansion: immediate return to reset values. No partial key survives as valid.

## Configuration
- `AES_KS_ZEROIZE_EN` defined:
  - Adds `zeroize_i`.
  - An edge with `zeroize_i`=1 clears all rk[*] to 0, r to 0, and `rd_data_o` to 0. State → IDLE, `keys_valid_o` → 0.
  - Zeroize has priority over key accept and over an EXPAND step in the same cycle.
- Not defined: the port is absent and round keys persist until overwritten by the next expansion.

## Structure
- Shared `aes_pkg`:
  - `sbox` function.
  - `rcon` constant array.
  - `aes_word_t` (32-bit) and `aes_rk_t` (128-bit) typedefs.
  - `AES256_NUM_RK` = 15.
- One sub-module, `aes_sub_word`: 4 parallel S-box lookups, combinational.
- The RotWord mux, XOR chain, FSM, counter and register file stay in this block.

## Test plan
- FIPS-197 A.3 key 603deb10…0914dff4 → rk2 = 9ba354118e6925afa51a8b5f2067fcde; rk14 = fe4890d1e6188d0b046df344706c631e; `keys_valid_o` rises exactly 13 cycles after accept.
- Key 000102…1e1f, then read indices 14 down to 0 back-to-back → rk14 = 24fc79ccbf0979e9371ac23c6d68de36; one valid read per cycle at 1-cycle latency.
- `key_valid_i` held during EXPAND with a different key → ignored; results match the first key; the second key is accepted on the first DONE cycle.
- `rst_ni` pulsed low at step r=7 → all outputs at reset values; a fresh key then expands correctly.
- Read with `rd_idx_i`=15 → `rd_data_o` = 0, `rd_valid_o` = 1.
- With `AES_KS_ZEROIZE_EN`: `zeroize_i` in DONE → reads of 0..14 return 0 and `keys_valid_o` = 0. `zeroize_i` coinciding with key accept → zeroize wins and state = IDLE.
